// File: rtl/tone_detector.sv
// Tone frequency meter: times rising-edge periods of a square wave and
// divides the millisecond timebase by the period to report Hz.
module tone_detector #(
  parameter int SILENCE_MS  = 100,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sound_in,
  input  logic [15:0] ticks_per_milli,
  output logic [9:0]  frequency,
  output logic        freq_valid,
  output logic        silent,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DIVIDE
  } state_e;

  localparam logic [15:0] SIL = 16'(SILENCE_MS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  state_e                 state_q, state_d;
  logic [31:0]            per_q, per_d;
  logic [15:0]            pre_q, pre_d;
  logic [15:0]            ms_q, ms_d;
  logic [31:0]            p_q, p_d;
  logic [31:0]            rem_q, rem_d;
  logic [31:0]            quo_q, quo_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [9:0]             freq_q, freq_d;
  logic                   valid_q, valid_d;
  logic                   silent_q, silent_d;

  logic        en;
  logic        edge_det;
  logic        ovr;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] quo_nx;

  assign en       = |ticks_per_milli;
  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

  // One restoring-division step: shift the next dividend bit into the remainder.
  assign rem_sh = {rem_q, quo_q[31]};
  assign ge     = rem_sh >= {1'b0, p_q};
  assign quo_nx = {quo_q[30:0], ge};

  always_comb begin
    state_d  = state_q;
    per_d    = (per_q == '1) ? per_q : per_q + 32'd1;
    pre_d    = pre_q + 16'd1;
    ms_d     = ms_q;
    p_d      = p_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    freq_d   = freq_q;
    valid_d  = 1'b0;
    silent_d = silent_q;
    ovr      = 1'b0;

    if (pre_q == ticks_per_milli - 16'd1) begin
      pre_d = '0;
      if (ms_q != '1) ms_d = ms_q + 16'd1;
    end
    if (edge_det) begin
      per_d = 32'd1;
      pre_d = '0;
      ms_d  = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (edge_det) state_d = MEASURE;
      end
      MEASURE: begin
        if (edge_det) begin
          p_d     = per_q;
          cnt_d   = '0;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (edge_det) ovr = 1'b1;
        if (cnt_q == 6'd0) begin
          rem_d = '0;
          // Adding half the period rounds the quotient to nearest.
          quo_d = 32'(ticks_per_milli) * 32'd1000 + {1'b0, p_q[31:1]};
          cnt_d = 6'd1;
        end else begin
          rem_d = ge ? 32'(rem_sh - {1'b0, p_q}) : rem_sh[31:0];
          quo_d = quo_nx;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd32) begin
            freq_d   = (|quo_nx[31:10]) ? 10'h3FF : quo_nx[9:0];
            valid_d  = 1'b1;
            silent_d = 1'b0;
            state_d  = MEASURE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // ms_d is already cleared by an edge, so an edge beats the timeout.
    if (!silent_q && ms_d >= SIL) begin
      freq_d   = '0;
      silent_d = 1'b1;
      valid_d  = 1'b1;
      state_d  = IDLE;
    end

    if (!en) begin
      state_d  = IDLE;
      per_d    = '0;
      pre_d    = '0;
      ms_d     = '0;
      freq_d   = '0;
      silent_d = 1'b1;
      valid_d  = !silent_q;
      ovr      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      state_q  <= IDLE;
      per_q    <= '0;
      pre_q    <= '0;
      ms_q     <= '0;
      p_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      freq_q   <= '0;
      valid_q  <= 1'b0;
      silent_q <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sound_in};
      prev_q   <= sync_q[SYNC_STAGES-1];
      state_q  <= state_d;
      per_q    <= per_d;
      pre_q    <= pre_d;
      ms_q     <= ms_d;
      p_q      <= p_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      freq_q   <= freq_d;
      valid_q  <= valid_d;
      silent_q <= silent_d;
    end
  end

  assign frequency  = freq_q;
  assign freq_valid = valid_q;
  assign silent     = silent_q;
  assign overrun    = ovr;

endmodule

// File: doc/tone_detector.md
Name: tone_detector

Overview:
- Receive-side counterpart of the tone generator: measures the frequency of an incoming square-wave tone and reports it in Hz.
- Reports a 10-bit frequency using the same `ticks_per_milli` timebase as the generator, so a player's tone can be compared against the expected note.
- Detects silence (no edges for a timeout) and reports frequency 0.
- Sits between the sound/tone input path and the game FSM's note-check logic.

Parameters:
- SILENCE_MS, 100, milliseconds without a rising edge before the tone is declared silent.
- SYNC_STAGES, 2, synchronizer flops on `sound_in`; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sound_in  input  1  asynchronous square-wave tone input
- ticks_per_milli  input  16  clk ticks per millisecond; 0 = block disabled
- frequency  output  10  last measured frequency in Hz, saturating at 1023; 0 = silent
- freq_valid  output  1  one-cycle pulse when `frequency` is updated
- silent  output  1  high while no tone is present
- overrun  output  1  one-cycle pulse when a rising edge arrives while the divider is busy

Behaviour:
- Reset (`rst_n` low, async): `frequency`=0, `silent`=1, `freq_valid`=0, `overrun`=0.
  - All counters cleared; FSM=IDLE; `have_ref`=0; synchronizer flops cleared.
- Input path:
  - `sound_in` passes through SYNC_STAGES flops, then one edge-detect register.
  - A rising edge is "detected" in the cycle where synchronized=1 and previous=0, i.e. SYNC_STAGES+1 cycles after the input transition.
- Period counter (32 bit):
  - Counts clk cycles since the last detected rising edge; saturates at 0xFFFFFFFF.
  - Each detected edge restarts it: next value 1, so the edge-to-edge distance equals the captured value.
- Millisecond timer:
  - Prescaler counts 0..ticks_per_milli-1; on wrap it increments `ms_count` (saturating).
  - Both the prescaler and `ms_count` clear on every detected edge.
- FSM states: IDLE, MEASURE, DIVIDE.
- IDLE (no reference edge):
  - On a detected edge: `have_ref`=1, go to MEASURE. No result is produced.
- MEASURE:
  - On a detected edge: latch period P = counter value, go to DIVIDE.
  - The period counter keeps running from that edge, so back-to-back measurement is continuous.
- DIVIDE: restoring division, one quotient bit per cycle.
  - Dividend D = ticks_per_milli*1000 + (P>>1), computed in 32 bits (max 65535000 fits). This gives round-to-nearest.
  - Quotient Q = floor(D/P).
  - Cycle budget: 1 load cycle + 32 iteration cycles + 1 output cycle.
  - `freq_valid` pulses and `frequency` updates exactly 34 cycles after the detected-edge cycle.
  - `frequency` = (Q > 1023) ? 1023 : Q[9:0]; `silent` <= 0.
  - Then return to MEASURE.
- Edge while in DIVIDE:
  - `overrun` pulses in the edge cycle; the period counter and ms timer restart normally.
  - The in-flight division completes and its result is still reported.
  - The edge is not latched as a new period end; the next edge after return to MEASURE ends the next period.
  - Consequence: any period shorter than 34 cycles yields overrun and no new result.
- Silence:
  - When `ms_count` reaches SILENCE_MS and `silent`=0: `frequency`<=0, `silent`<=1, `freq_valid` pulses once, `have_ref`<=0, FSM -> IDLE.
  - If DIVIDE is in progress at that moment, it is abandoned.
  - A steady high input and a steady low input are both silence.
  - No repeated pulses while silence persists.
- ticks_per_milli == 0:
  - FSM is held in IDLE; counters are cleared; `frequency`=0; `silent`=1; no `freq_valid` pulses.
  - If `silent` was 0 when 0 is applied: one `freq_valid` pulse with frequency=0.
- P=0 cannot occur, since a captured period is at least 1. Divide-by-zero is therefore unreachable and needs no handling.
- Simultaneous silence-timeout and detected edge in the same cycle: the edge wins; the timer clears and no silence is declared.

Test Plan:
- Reset release with `sound_in`=0, ticks_per_milli=50 -> frequency=0, silent=1, no freq_valid during the first 4999 cycles.
- ticks_per_milli=50, square wave with 100-cycle period -> first edge gives no result; each later edge gives freq_valid 34 cycles after the detected edge with frequency=500 and silent=0.
- Period switched from 100 to 200 cycles mid-stream -> next result is 250, with no spurious intermediate values.
- Period 40 cycles (1250 Hz) -> frequency=1023 (saturated), no overrun; period 20 cycles -> an overrun pulse on every other edge and frequency=1023 on each completed division.
- Tone at 500 Hz, then input held high -> exactly one freq_valid with frequency=0 and silent=1, 5000 cycles (100 ms) after the last detected edge; restarting the tone needs two edges before 500 reappears.
- `rst_n` asserted during DIVIDE -> outputs return to reset values immediately (asynchronously); after release the first edge produces no result.
